// File: rtl/cla_pkg.sv
// Shared constants and FSM encoding for the sequential CLA subtract/compare path.
package cla_pkg;

    localparam int CLA_W     = 64;
    localparam int CLA_SLICE = 16;
    localparam int CLA_NS    = CLA_W / CLA_SLICE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/CLA_16_bit.sv
// 16-bit two-level carry-lookahead adder slice: four 4-bit groups, group
// generate/propagate combined by a second lookahead level.
module CLA_16_bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout,
    output logic        pout,
    output logic        gout
);

    logic [15:0] p;
    logic [15:0] g;
    logic [15:0] c;
    logic [3:0]  gp;
    logic [3:0]  gg;
    logic [4:0]  gc;

    // Bit/group propagate-generate, group carries, then per-bit carries and sum.
    always_comb begin
        p  = a ^ b;
        g  = a & b;
        gp = '0;
        gg = '0;
        c  = '0;
        for (int j = 0; j < 4; j++) begin
            gp[j] = &p[4*j +: 4];
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
        end
        gc[0] = cin;
        gc[1] = gg[0] | (gp[0] & cin);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & cin);
        gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
        for (int j = 0; j < 4; j++) begin
            c[4*j]   = gc[j];
            c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
                     | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
        end
        sum  = p ^ c;
        cout = gc[4];
        pout = &gp;
        gout = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
             | (gp[3] & gp[2] & gp[1] & gg[0]);
    end

endmodule

// File: rtl/cla_seq_subtractor.sv
// Multi-cycle W-bit subtract/compare unit: a - b = a + ~b + 1, one CLA slice
// per cycle with a registered inter-slice carry, valid/ready on both sides.
// SLICE must match the 16-bit CLA slice width.
module cla_seq_subtractor
    import cla_pkg::*;
#(
    parameter int W     = CLA_W,
    parameter int SLICE = CLA_SLICE
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic         borrow,
    output logic         zero,
    output logic         ovf,
    output logic         lt_s
);

    localparam int NS = W / SLICE;
    localparam int KW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NS - 1);

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   opa;
    logic [W-1:0]   opb_n;
    logic [W-1:0]   diff_nxt;
    logic           carry;
    logic [KW-1:0]  k;
    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] sum_sl;
    logic           cout_sl;
    logic           slice_pout_unused;
    logic           slice_gout_unused;
    logic           ovf_nxt;

    // Two's-complement overflow of a - b: operand signs differ and the
    // result sign differs from the minuend.
    function automatic logic calc_ovf(input logic a_msb, input logic b_msb,
                                      input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

    CLA_16_bit u_slice (
        .a    (a_sl),
        .b    (b_sl),
        .cin  (carry),
        .sum  (sum_sl),
        .cout (cout_sl),
        .pout (slice_pout_unused),
        .gout (slice_gout_unused)
    );

    // Select the current slice and merge its sum into the running difference.
    always_comb begin
        a_sl     = opa[int'(k)*SLICE +: SLICE];
        b_sl     = opb_n[int'(k)*SLICE +: SLICE];
        diff_nxt = diff;
        diff_nxt[int'(k)*SLICE +: SLICE] = sum_sl;
        ovf_nxt  = calc_ovf(opa[W-1], ~opb_n[W-1], diff_nxt[W-1]);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = CALC;
            end
            CALC: begin
                if (k == K_LAST) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, slice accumulation, carry chain and final flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa    <= '0;
            opb_n  <= '0;
            diff   <= '0;
            carry  <= 1'b0;
            k      <= '0;
            borrow <= 1'b0;
            zero   <= 1'b0;
            ovf    <= 1'b0;
            lt_s   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opa   <= a;
                        opb_n <= ~b;
                        carry <= 1'b1;
                        k     <= '0;
                    end
                end
                CALC: begin
                    diff  <= diff_nxt;
                    carry <= cout_sl;
                    if (k == K_LAST) begin
                        k      <= '0;
                        borrow <= ~cout_sl;
                        zero   <= (diff_nxt == '0);
                        ovf    <= ovf_nxt;
                        lt_s   <= diff_nxt[W-1] ^ ovf_nxt;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_seq_subtractor.sv
// Self-checking bench for cla_seq_subtractor: scoreboard of expected results.
module tb_cla_seq_subtractor;

    typedef struct packed {
        logic [63:0] diff;
        logic        borrow;
        logic        zero;
        logic        ovf;
        logic        lt_s;
    } res_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] diff;
    logic        borrow;
    logic        zero;
    logic        ovf;
    logic        lt_s;

    res_t sb[$];
    int   errors = 0;
    int   checks = 0;

    cla_seq_subtractor #(.W(64), .SLICE(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .zero      (zero),
        .ovf       (ovf),
        .lt_s      (lt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic res_t model(input logic [63:0] x, input logic [63:0] y);
        res_t r;
        logic [64:0] sx;
        r.diff   = x - y;
        r.borrow = (x < y);
        r.zero   = (x == y);
        sx       = {x[63], x} - {y[63], y};
        r.ovf    = sx[64] ^ sx[63];
        r.lt_s   = ($signed(x) < $signed(y));
        return r;
    endfunction

    function automatic res_t observed();
        return {diff, borrow, zero, ovf, lt_s};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] x, input logic [63:0] y, output int lat);
        bit hs;
        hs = 0;
        a = x;
        b = y;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !hs; i++) begin
            if (in_ready) hs = 1;
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (!hs) begin
            errors++;
            $display("FAIL send_handshake: in_ready=%b, required 1 within 20 cycles", in_ready);
        end
        lat = 1;
        while (!out_valid && lat < 30) begin
            step();
            lat++;
        end
    endtask

    task automatic receive(input string name);
        res_t e;
        res_t o;
        for (int i = 0; i < 30 && !out_valid; i++) step();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_valid: out_valid=%b, required 1", name, out_valid);
        end
        if (sb.size() == 0) begin
            e = '0;
            errors++;
            $display("FAIL %s_sb: scoreboard empty, required an entry", name);
        end else begin
            e = sb.pop_front();
        end
        o = observed();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL %s_result: got diff=%h b/z/o/l=%b%b%b%b, required diff=%h b/z/o/l=%b%b%b%b",
                     name, o.diff, o.borrow, o.zero, o.ovf, o.lt_s,
                     e.diff, e.borrow, e.zero, e.ovf, e.lt_s);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL %s_accept: out_valid/in_ready=%b%b, required 01", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, diff, borrow, zero, ovf, lt_s} !== {1'b1, 1'b0, 64'h0, 4'b0000}) begin
            errors++;
            $display("FAIL reset_values: rdy=%b vld=%b diff=%h flags=%b%b%b%b, required 1 0 0 0000",
                     in_ready, out_valid, diff, borrow, zero, ovf, lt_s);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release: rdy/vld=%b%b, required 10", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [63:0] va[5];
        logic [63:0] vb[5];
        res_t        ve[5];
        int          lat;
        va[0] = 64'h10;                  vb[0] = 64'h3;
        ve[0] = {64'hD, 4'b0000};
        va[1] = 64'h0000_0001_0000_0000; vb[1] = 64'h1;
        ve[1] = {64'h0000_0000_FFFF_FFFF, 4'b0000};
        va[2] = 64'h1234_5678_9ABC_DEF0; vb[2] = 64'h1234_5678_9ABC_DEF0;
        ve[2] = {64'h0, 4'b0100};
        va[3] = 64'h0;                   vb[3] = 64'h1;
        ve[3] = {64'hFFFF_FFFF_FFFF_FFFF, 4'b1001};
        va[4] = 64'h8000_0000_0000_0000; vb[4] = 64'h1;
        ve[4] = {64'h7FFF_FFFF_FFFF_FFFF, 4'b0011};
        for (int i = 0; i < 5; i++) begin
            sb.push_back(ve[i]);
            send(va[i], vb[i], lat);
            checks++;
            if (lat != 5) begin
                errors++;
                $display("FAIL directed%0d_latency: got %0d cycles, required 5", i, lat);
            end
            receive($sformatf("directed%0d", i));
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] a1, b1, a2, b2;
        int          lat;
        a1 = {$urandom, $urandom};
        b1 = {$urandom, $urandom};
        a2 = {$urandom, $urandom};
        b2 = {$urandom, $urandom};
        sb.push_back(model(a1, b1));
        send(a1, b1, lat);
        sb.push_back(model(a2, b2));
        a = a2;
        b = b2;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({out_valid, in_ready} !== 2'b10 || observed() !== sb[0]) begin
                errors++;
                $display("FAIL bp_hold%0d: vld/rdy=%b%b diff=%h, required 10 diff=%h",
                         i, out_valid, in_ready, diff, sb[0].diff);
            end
            step();
        end
        receive("bp_first");
        step();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_next_accept: in_ready=%b, required 0", in_ready);
        end
        a = ~a2;
        b = ~b2;
        for (int i = 0; i < 30 && !out_valid; i++) step();
        in_valid = 1'b0;
        receive("bp_second");
    endtask

    task automatic test_reset_midop();
        bit seen;
        int lat;
        a = 64'h0000_0000_0000_FFFF;
        b = 64'h0;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !in_ready; i++) step();
        step();
        in_valid = 1'b0;
        step();
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, diff, borrow, zero, ovf, lt_s} !== {1'b1, 1'b0, 64'h0, 4'b0000}) begin
            errors++;
            $display("FAIL midop_reset: rdy=%b vld=%b diff=%h flags=%b%b%b%b, required 1 0 0 0000",
                     in_ready, out_valid, diff, borrow, zero, ovf, lt_s);
        end
        #3;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid) seen = 1;
        end
        checks++;
        if (seen || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midop_quiet: spurious out_valid=%b in_ready=%b, required 0 and 1", seen, in_ready);
        end
        sb.push_back({64'hFFFF_FFFF_FFFF_FFFE, 4'b1001});
        send(64'h5, 64'h7, lat);
        checks++;
        if (lat != 5) begin
            errors++;
            $display("FAIL midop_latency: got %0d cycles, required 5", lat);
        end
        receive("midop_after");
    endtask

    task automatic test_back_to_back();
        int   issued;
        int   got;
        int   last;
        bit   hs;
        res_t e;
        res_t o;
        issued = 0;
        got = 0;
        last = -1;
        out_ready = 1'b1;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        for (int cyc = 0; cyc < 200 && got < 5; cyc++) begin
            in_valid = (issued < 5);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    e = '0;
                    errors++;
                    $display("FAIL b2b_sb: scoreboard empty, required an entry");
                end else begin
                    e = sb.pop_front();
                end
                o = observed();
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL b2b_result%0d: got diff=%h b/z/o/l=%b%b%b%b, required diff=%h b/z/o/l=%b%b%b%b",
                             got, o.diff, o.borrow, o.zero, o.ovf, o.lt_s,
                             e.diff, e.borrow, e.zero, e.ovf, e.lt_s);
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != 6) begin
                        errors++;
                        $display("FAIL b2b_interval: got %0d cycles, required 6", cyc - last);
                    end
                end
                last = cyc;
                got++;
            end
            hs = in_valid && in_ready;
            if (hs) begin
                sb.push_back(model(a, b));
                issued++;
            end
            step();
            if (hs) begin
                a = {$urandom, $urandom};
                b = (issued % 2 == 0) ? a : {$urandom, $urandom};
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (got != 5) begin
            errors++;
            $display("FAIL b2b_count: got %0d results, required 5", got);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
